// File: rtl/rename_regfile.sv
// Architectural register file with rename-tag (register status) table.
// Issue reads two operands as value-or-ROB-tag and renames the destination.
// Commit writes the retired value and frees the tag only when the retiring
// instruction is still the newest producer of that register.
module rename_regfile #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int ROB_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rollback,
  input  logic [REG_AW:0]   rs1,
  input  logic [REG_AW:0]   rs2,
  input  logic [REG_AW:0]   rd,
  input  logic              issue_sgn,
  input  logic [ROB_W-1:0]  rob_new_entry,
  output logic [ROB_W-1:0]  Qj,
  output logic [ROB_W-1:0]  Qk,
  output logic [XLEN-1:0]   Vj,
  output logic [XLEN-1:0]   Vk,
  input  logic              commit_sgn,
  input  logic [ROB_W-1:0]  rob_entry,
  input  logic [REG_AW:0]   rob_des,
  input  logic [XLEN-1:0]   rob_result
);
  localparam int NREG = 1 << REG_AW;
  localparam int NRD  = 2;
  // All-ones tag is reserved; the ROB never hands it out.
  localparam logic [ROB_W-1:0] NULL_TAG = '1;

  logic [NREG-1:0][XLEN-1:0]  value_q, value_d;
  logic [NREG-1:0][ROB_W-1:0] tag_q,   tag_d;
  logic [NREG-1:0]            busy_q,  busy_d;

  logic [REG_AW-1:0] cidx, ridx;
  logic              commit_wr, issue_wr;

  assign cidx      = rob_des[REG_AW-1:0];
  assign ridx      = rd[REG_AW-1:0];
  // x0 and "no register" encodings never touch state.
  assign commit_wr = commit_sgn && !rob_des[REG_AW] && (cidx != '0);
  assign issue_wr  = issue_sgn && !rd[REG_AW] && (ridx != '0);

  // Read ports: one generated instance per source operand.
  logic [NRD-1:0][REG_AW:0]  rs_all;
  logic [NRD-1:0][ROB_W-1:0] q_all;
  logic [NRD-1:0][XLEN-1:0]  v_all;

  assign rs_all = {rs2, rs1};

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [REG_AW-1:0] idx;
    logic [ROB_W-1:0]  q;
    logic [XLEN-1:0]   v;
    assign idx = rs_all[p][REG_AW-1:0];
    // Value-or-tag lookup on pre-edge state, with same-cycle commit bypass.
    always_comb begin
      q = NULL_TAG;
      v = '0;
      if (!rs_all[p][REG_AW] && (idx != '0)) begin
        if (!busy_q[idx]) begin
          v = value_q[idx];
        end else if (commit_sgn && (rob_entry == tag_q[idx])) begin
          v = rob_result;
        end else begin
          q = tag_q[idx];
        end
      end
    end
    assign q_all[p] = q;
    assign v_all[p] = v;
  end

  assign Qj = q_all[0];
  assign Qk = q_all[1];
  assign Vj = v_all[0];
  assign Vk = v_all[1];

  // Next state: commit first, then rollback or issue override busy/tag.
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    if (rdy) begin
      // The committing instr is older than any flush, so its value lands.
      if (commit_wr) begin
        value_d[cidx] = rob_result;
        if (tag_q[cidx] == rob_entry) begin
          busy_d[cidx] = 1'b0;
          tag_d[cidx]  = NULL_TAG;
        end
      end
      if (rollback) begin
        busy_d = '0;
        tag_d  = '1;
      end else if (issue_wr) begin
        busy_d[ridx] = 1'b1;
        tag_d[ridx]  = rob_new_entry;
      end
    end
  end

  // State registers; rdy=0 hold is folded into the next-state logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      tag_q   <= '1;
      busy_q  <= '0;
    end else begin
      value_q <= value_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Bench for rename_regfile: per-cycle vector table, expected read results
// queued on drive and popped when the combinational outputs are sampled.
module tb_rename_regfile;
  localparam int XLEN = 32, REG_AW = 5, ROB_W = 4;
  localparam logic [3:0] F  = 4'hF;
  localparam logic [5:0] NO = 6'h20;

  logic              clk = 1'b0;
  logic              rst, rdy, rollback, issue_sgn, commit_sgn;
  logic [REG_AW:0]   rs1, rs2, rd, rob_des;
  logic [ROB_W-1:0]  rob_new_entry, rob_entry, Qj, Qk;
  logic [XLEN-1:0]   Vj, Vk, rob_result;

  rename_regfile #(.XLEN(XLEN), .REG_AW(REG_AW), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .rs1(rs1), .rs2(rs2), .rd(rd), .issue_sgn(issue_sgn),
    .rob_new_entry(rob_new_entry), .Qj(Qj), .Qk(Qk), .Vj(Vj), .Vk(Vk),
    .commit_sgn(commit_sgn), .rob_entry(rob_entry), .rob_des(rob_des),
    .rob_result(rob_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, rdy, rb, iss;
    logic [5:0] rd;  logic [3:0] ntag;
    logic com;       logic [3:0] ent; logic [5:0] des; logic [31:0] res;
    logic [5:0] rs1, rs2;
    logic [3:0] qj;  logic [31:0] vj;
    logic [3:0] qk;  logic [31:0] vk;
  } vec_t;

  typedef struct {
    int idx;
    logic [3:0] qj; logic [31:0] vj;
    logic [3:0] qk; logic [31:0] vk;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int checks = 0, errors = 0;

  function automatic vec_t mk(
    input logic r, input logic y, input logic b, input logic i,
    input logic [5:0] d, input logic [3:0] t,
    input logic c, input logic [3:0] e, input logic [5:0] de, input logic [31:0] rs,
    input logic [5:0] a1, input logic [5:0] a2,
    input logic [3:0] eqj, input logic [31:0] evj,
    input logic [3:0] eqk, input logic [31:0] evk);
    vec_t v;
    v.rst = r; v.rdy = y; v.rb = b; v.iss = i; v.rd = d; v.ntag = t;
    v.com = c; v.ent = e; v.des = de; v.res = rs; v.rs1 = a1; v.rs2 = a2;
    v.qj = eqj; v.vj = evj; v.qk = eqk; v.vk = evk;
    return v;
  endfunction

  task automatic check(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; rdy = v.rdy; rollback = v.rb;
    issue_sgn = v.iss; rd = v.rd; rob_new_entry = v.ntag;
    commit_sgn = v.com; rob_entry = v.ent; rob_des = v.des; rob_result = v.res;
    rs1 = v.rs1; rs2 = v.rs2;
  endtask

  initial begin
    exp_t e;
    // rst rdy rb iss rd ntag com ent des res rs1 rs2 qj vj qk vk
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       5, 0,  F,0,       F,0));
    tbl.push_back(mk(0,1,0, 1,3,2, 0,0,0,0,       3, NO, F,0,       F,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       3, 3,  2,0,       2,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 1,2,3,'hDEAD,  3, 4,  F,'hDEAD,  F,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       3, NO, F,'hDEAD,  F,0));
    tbl.push_back(mk(0,1,0, 1,7,1, 0,0,0,0,       7, NO, F,0,       F,0));
    tbl.push_back(mk(0,1,0, 1,7,4, 0,0,0,0,       7, NO, 1,0,       F,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 1,1,7,9,       7, NO, 4,0,       F,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       7, NO, 4,0,       F,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 1,4,7,'h77,    7, NO, F,'h77,    F,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       7, NO, F,'h77,    F,0));
    tbl.push_back(mk(0,1,0, 1,8,3, 0,0,0,0,       8, NO, F,0,       F,0));
    tbl.push_back(mk(0,1,0, 1,8,5, 1,3,8,'h11,    8, 8,  F,'h11,    F,'h11));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       8, NO, 5,0,       F,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 1,5,8,'h22,    NO,8,  F,0,       F,'h22));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       8, NO, F,'h22,    F,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 1,9,4,'h55,    4, NO, F,0,       F,0));
    tbl.push_back(mk(0,1,0, 1,4,6, 0,0,0,0,       4, NO, F,'h55,    F,0));
    tbl.push_back(mk(0,1,1, 1,10,7,1,2,11,'hAB,   4, 11, 6,0,       F,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       4, 10, F,'h55,    F,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       11,4,  F,'hAB,    F,'h55));
    tbl.push_back(mk(0,1,0, 1,0,3, 0,0,0,0,       0, NO, F,0,       F,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       0, 0,  F,0,       F,0));
    tbl.push_back(mk(0,0,0, 1,9,2, 1,0,12,'h33,   9, 12, F,0,       F,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       9, 12, F,0,       F,0));
    tbl.push_back(mk(0,1,0, 1,13,1,0,0,0,0,       13,NO, F,0,       F,0));
    tbl.push_back(mk(0,0,1, 0,0,0, 0,0,0,0,       13,4,  1,0,       F,'h55));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       13,NO, 1,0,       F,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 1,1,13,'h99,   13,NO, F,'h99,    F,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       13,NO, 1,0,       F,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 1,1,13,'h99,   13,NO, F,'h99,    F,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       13,NO, F,'h99,    F,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 1,7,0,'hEE,    0, NO, F,0,       F,0));
    tbl.push_back(mk(1,1,0, 1,5,2, 0,0,0,0,       4, 13, F,'h55,    F,'h99));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       4, 13, F,0,       F,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       5, 7,  F,0,       F,0));

    // Hand-written power-on reset: two cycles with everything idle.
    drive(mk(1,1,0, 0,0,0, 0,0,0,0, NO,NO, F,0,F,0));
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      e.idx = i; e.qj = tbl[i].qj; e.vj = tbl[i].vj; e.qk = tbl[i].qk; e.vk = tbl[i].vk;
      sb.push_back(e);
      #2;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard row %0d: queue empty", i);
      end else begin
        e = sb.pop_front();
        check("Qj", e.idx, {28'd0, Qj}, {28'd0, e.qj});
        check("Vj", e.idx, Vj, e.vj);
        check("Qk", e.idx, {28'd0, Qk}, {28'd0, e.qk});
        check("Vk", e.idx, Vk, e.vk);
      end
    end

    // Hand-written: a long run of issues to one reg, then only the newest
    // producer's commit frees it.
    @(negedge clk);
    drive(mk(0,1,0, 1,20,1, 0,0,0,0, NO,NO, F,0,F,0));
    for (int t = 2; t < 6; t++) begin
      @(negedge clk);
      drive(mk(0,1,0, 1,20,t[3:0], 1,t[3:0]-4'd1,20,t, NO,NO, F,0,F,0));
    end
    @(negedge clk);
    drive(mk(0,1,0, 0,0,0, 0,0,0,0, 20,NO, F,0,F,0));
    #2;
    check("chainQ", 99, {28'd0, Qj}, 32'd5);
    check("chainV", 99, Vj, 32'd0);
    @(negedge clk);
    drive(mk(0,1,0, 0,0,0, 1,5,20,'hC0DE, 20,NO, F,0,F,0));
    @(negedge clk);
    drive(mk(0,1,0, 0,0,0, 0,0,0,0, 20,NO, F,0,F,0));
    #2;
    check("chainQ2", 100, {28'd0, Qj}, {28'd0, F});
    check("chainV2", 100, Vj, 32'hC0DE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
